// File: rtl/decode_pkg.sv
// Shared constants for the MIPS decode stage: opcodes, instruction classes
// and the FIFO entry width.
package decode_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;

    localparam logic [1:0] ICLASS_R = 2'd0;
    localparam logic [1:0] ICLASS_I = 2'd1;
    localparam logic [1:0] ICLASS_J = 2'd2;

    localparam int XLEN_DEFAULT = 32;
    localparam int ENTRY_W      = 32 + XLEN_DEFAULT;

    // Entry is {instr, pc}; width follows the instantiated XLEN.
    function automatic int entry_width(input int xlen);
        return 32 + xlen;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers; flush and reset both empty it.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_wr;
    logic             do_rd;

    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        do_wr    = wr_en && !full && !flush && !rst;
        do_rd    = rd_en && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
        if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/instr_decode_stage.sv
// MIPS decode stage: input FIFO feeding a registered decode bundle with
// valid/ready handshakes on both sides.
module instr_decode_stage
    import decode_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [5:0]      opcode,
    output logic [4:0]      rs,
    output logic [4:0]      rt,
    output logic [4:0]      rd,
    output logic [4:0]      shamt,
    output logic [5:0]      funct,
    output logic [XLEN-1:0] imm_ext,
    output logic [XLEN-1:0] jump_target,
    output logic [XLEN-1:0] branch_target,
    output logic [XLEN-1:0] pc_plus4,
    output logic [1:0]      iclass
);

    localparam int EW = entry_width(XLEN);

    logic [EW-1:0]   head;
    logic            fifo_full, fifo_empty;
    logic            push, load;
    logic [31:0]     h_instr;
    logic [XLEN-1:0] h_pc, h_pc4, h_sext;

    logic            out_valid_q, out_valid_d;
    logic [5:0]      opcode_q, opcode_d, funct_q, funct_d;
    logic [4:0]      rs_q, rs_d, rt_q, rt_d, rd_q, rd_d, shamt_q, shamt_d;
    logic [XLEN-1:0] imm_q, imm_d, jt_q, jt_d, bt_q, bt_d, pc4_q, pc4_d;
    logic [1:0]      iclass_q, iclass_d;

    // in_ready depends only on occupancy and reset, never on out_ready.
    assign in_ready = !rst && !fifo_full;
    assign push     = in_valid && in_ready;
    assign load     = (!out_valid_q || out_ready) && !fifo_empty;

    sync_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .wr_en   (push),
        .wr_data ({instr, pc}),
        .rd_en   (load && !flush),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        h_instr = head[EW-1 -: 32];
        h_pc    = head[XLEN-1:0];
        h_pc4   = h_pc + XLEN'(4);
        h_sext  = {{(XLEN-16){h_instr[15]}}, h_instr[15:0]};

        opcode_d = opcode_q;
        rs_d     = rs_q;
        rt_d     = rt_q;
        rd_d     = rd_q;
        shamt_d  = shamt_q;
        funct_d  = funct_q;
        imm_d    = imm_q;
        jt_d     = jt_q;
        bt_d     = bt_q;
        pc4_d    = pc4_q;
        iclass_d = iclass_q;

        if (load) begin
            opcode_d = h_instr[31:26];
            rs_d     = h_instr[25:21];
            rt_d     = h_instr[20:16];
            rd_d     = h_instr[15:11];
            shamt_d  = h_instr[10:6];
            funct_d  = h_instr[5:0];
            pc4_d    = h_pc4;
            jt_d     = {h_pc4[XLEN-1:28], h_instr[25:0], 2'b00};
            bt_d     = h_pc4 + {h_sext[XLEN-3:0], 2'b00};
            if (h_instr[31:26] == OP_ANDI || h_instr[31:26] == OP_ORI ||
                h_instr[31:26] == OP_XORI)
                imm_d = {{(XLEN-16){1'b0}}, h_instr[15:0]};
            else
                imm_d = h_sext;
            if (h_instr[31:26] == OP_RTYPE)
                iclass_d = ICLASS_R;
            else if (h_instr[31:26] == OP_J || h_instr[31:26] == OP_JAL)
                iclass_d = ICLASS_J;
            else
                iclass_d = ICLASS_I;
        end

        if (flush)          out_valid_d = 1'b0;
        else if (load)      out_valid_d = 1'b1;
        else if (out_ready) out_valid_d = 1'b0;
        else                out_valid_d = out_valid_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            opcode_q    <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            rd_q        <= '0;
            shamt_q     <= '0;
            funct_q     <= '0;
            imm_q       <= '0;
            jt_q        <= '0;
            bt_q        <= '0;
            pc4_q       <= '0;
            iclass_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            opcode_q    <= opcode_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            rd_q        <= rd_d;
            shamt_q     <= shamt_d;
            funct_q     <= funct_d;
            imm_q       <= imm_d;
            jt_q        <= jt_d;
            bt_q        <= bt_d;
            pc4_q       <= pc4_d;
            iclass_q    <= iclass_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign opcode        = opcode_q;
    assign rs            = rs_q;
    assign rt            = rt_q;
    assign rd            = rd_q;
    assign shamt         = shamt_q;
    assign funct         = funct_q;
    assign imm_ext       = imm_q;
    assign jump_target   = jt_q;
    assign branch_target = bt_q;
    assign pc_plus4      = pc4_q;
    assign iclass        = iclass_q;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Scoreboard bench for instr_decode_stage: directed vectors with hand-computed
// decode results, checked by a monitor whenever a bundle is transferred.
module tb_instr_decode_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] instr, pc, imm_ext, jump_target, branch_target, pc_plus4;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [1:0]  iclass;

    always #5 clk = ~clk;

    instr_decode_stage #(.DEPTH(2), .XLEN(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .instr         (instr),
        .pc            (pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .opcode        (opcode),
        .rs            (rs),
        .rt            (rt),
        .rd            (rd),
        .shamt         (shamt),
        .funct         (funct),
        .imm_ext       (imm_ext),
        .jump_target   (jump_target),
        .branch_target (branch_target),
        .pc_plus4      (pc_plus4),
        .iclass        (iclass)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sh;
        logic [5:0]  fn;
        logic [31:0] imm;
        logic [31:0] jt;
        logic [31:0] bt;
        logic [31:0] pp4;
        logic [1:0]  ic;
    } vec_t;

    vec_t vecs[8];
    vec_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        vec_t e;
        if (!rst && !flush && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: got opcode 0x%02h pc_plus4 0x%08h expected nothing",
                         opcode, pc_plus4);
            end else begin
                e = exp_q.pop_front();
                chk("opcode", 32'(opcode), 32'(e.op));
                chk("rs", 32'(rs), 32'(e.rs));
                chk("rt", 32'(rt), 32'(e.rt));
                chk("rd", 32'(rd), 32'(e.rd));
                chk("shamt", 32'(shamt), 32'(e.sh));
                chk("funct", 32'(funct), 32'(e.fn));
                chk("imm_ext", imm_ext, e.imm);
                chk("jump_target", jump_target, e.jt);
                chk("branch_target", branch_target, e.bt);
                chk("pc_plus4", pc_plus4, e.pp4);
                chk("iclass", 32'(iclass), 32'(e.ic));
            end
        end
    end

    task automatic push(input int i, output int waited);
        waited   = 0;
        in_valid = 1'b1;
        instr    = vecs[i].instr;
        pc       = vecs[i].pc;
        @(negedge clk);
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (in_ready) exp_q.push_back(vecs[i]);
        else chk("push_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int c = 0;
        while (exp_q.size() > 0 && c < 50) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk({"drain_", tag}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic try_push(input int i, inout int acc);
        in_valid = 1'b1;
        instr    = vecs[i].instr;
        pc       = vecs[i].pc;
        @(negedge clk);
        if (in_ready) begin
            acc++;
            exp_q.push_back(vecs[i]);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int acc;
        int cnt;

        //                instr          pc            op     rs     rt     rd     sh     fn     imm            jt             bt             pc+4           ic
        vecs[0] = '{32'h012A4020, 32'h00400000, 6'h00, 5'd9,  5'd10, 5'd8,  5'd0,  6'h20, 32'h00004020, 32'h04A90080, 32'h00410084, 32'h00400004, 2'd0};
        vecs[1] = '{32'h2108FFFF, 32'h00400004, 6'h08, 5'd8,  5'd8,  5'd31, 5'd31, 6'h3F, 32'hFFFFFFFF, 32'h0423FFFC, 32'h00400004, 32'h00400008, 2'd1};
        vecs[2] = '{32'h3508FFFF, 32'h00400008, 6'h0D, 5'd8,  5'd8,  5'd31, 5'd31, 6'h3F, 32'h0000FFFF, 32'h0423FFFC, 32'h00400008, 32'h0040000C, 2'd1};
        vecs[3] = '{32'h08000004, 32'h00400000, 6'h02, 5'd0,  5'd0,  5'd0,  5'd0,  6'h04, 32'h00000004, 32'h00000010, 32'h00400014, 32'h00400004, 2'd2};
        vecs[4] = '{32'h1109FFFE, 32'h00400010, 6'h04, 5'd8,  5'd9,  5'd31, 5'd31, 6'h3E, 32'hFFFFFFFE, 32'h0427FFF8, 32'h0040000C, 32'h00400014, 2'd1};
        vecs[5] = '{32'h0C000100, 32'hF0000000, 6'h03, 5'd0,  5'd0,  5'd0,  5'd4,  6'h00, 32'h00000100, 32'hF0000400, 32'hF0000404, 32'hF0000004, 2'd2};
        vecs[6] = '{32'h3000FFFF, 32'hFFFFFFFC, 6'h0C, 5'd0,  5'd0,  5'd31, 5'd31, 6'h3F, 32'h0000FFFF, 32'h0003FFFC, 32'hFFFFFFFC, 32'h00000000, 2'd1};
        vecs[7] = '{32'h38428000, 32'h00001000, 6'h0E, 5'd2,  5'd2,  5'd16, 5'd0,  6'h00, 32'h00008000, 32'h010A0000, 32'hFFFE1004, 32'h00001004, 2'd1};

        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        instr     = '0;
        pc        = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_opcode", 32'(opcode), 32'd0);
        chk("rst_imm_ext", imm_ext, 32'd0);
        chk("rst_pc_plus4", pc_plus4, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Single R-type with latency check.
        out_ready = 1'b1;
        push(0, w);
        chk("lat_after_accept", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("lat_one_cycle", 32'(out_valid), 32'd1);
        drain("rtype");

        // Back-to-back stream at full rate.
        for (int i = 1; i < 8; i++) begin
            push(i, w);
            chk("stream_no_stall", 32'(w), 32'd0);
        end
        drain("stream");

        // Back-pressure: only DEPTH+1 fit.
        out_ready = 1'b0;
        acc = 0;
        for (int k = 0; k < 4; k++) try_push(k, acc);
        in_valid = 1'b0;
        chk("bp_accepted", 32'(acc), 32'd3);
        chk("bp_in_ready_full", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        cnt = 0;
        while (exp_q.size() > 0 && cnt < 20) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk("bp_drain_cycles", 32'(cnt), 32'd3);
        chk("bp_empty_after", 32'(out_valid), 32'd0);

        // Flush on a full stage with a concurrent input.
        out_ready = 1'b0;
        acc = 0;
        for (int k = 4; k < 7; k++) try_push(k, acc);
        chk("flush_fill", 32'(acc), 32'd3);
        in_valid = 1'b1;
        instr    = vecs[7].instr;
        pc       = vecs[7].pc;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);

        // Flush while in_ready=1: the concurrent write must be dropped.
        push(1, w);
        in_valid = 1'b1;
        instr    = vecs[2].instr;
        pc       = vecs[2].pc;
        flush    = 1'b1;
        @(negedge clk);
        chk("flush2_in_ready_before", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        chk("flush2_out_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("flush2_no_ghost", 32'(out_valid), 32'd0);
        push(3, w);
        drain("after_flush");

        // Reset mid-stream with two entries buffered.
        out_ready = 1'b0;
        push(4, w);
        push(5, w);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready_hold", 32'(in_ready), 32'd0);
        rst = 1'b0;
        exp_q.delete();
        #1;
        chk("midrst_in_ready_after", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_empty", 32'(out_valid), 32'd0);
        push(5, w);
        drain("after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_decode_stage.md
INSTR_DECODE_STAGE -- requirements
Module: instr_decode_stage

Interface
REQ-001 Parameter DEPTH, default 2: entries in the input FIFO; power of two, at least 2.
REQ-002 Parameter XLEN, default 32: width of the extended immediate, PC and targets; at least 32.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port flush, input, 1: synchronous discard of all buffered and output instructions.
REQ-006 Port in_valid, input, 1: instr and pc are valid this cycle.
REQ-007 Port in_ready, output, 1: the stage can accept an instruction this cycle.
REQ-008 Port instr, input, 32: MIPS instruction word.
REQ-009 Port pc, input, XLEN: address of instr.
REQ-010 Port out_valid, output, 1: the decoded bundle is valid.
REQ-011 Port out_ready, input, 1: the consumer accepts the bundle this cycle.
REQ-012 Outputs opcode[6], rs[5], rt[5], rd[5], shamt[5], funct[6]: raw instruction fields.
REQ-013 Output imm_ext, XLEN: extended 16-bit immediate.
REQ-014 Output jump_target, XLEN: computed J-type target.
REQ-015 Output branch_target, XLEN: computed branch target.
REQ-016 Output pc_plus4, XLEN: pc + 4.
REQ-017 Output iclass, 2: instruction class; 0 = R, 1 = I, 2 = J, 3 = unused.

Function
REQ-018 Input transfer occurs when in_valid && in_ready; the entry {instr, pc} is written to the FIFO.
REQ-019 Output transfer occurs when out_valid && out_ready.
REQ-020 Output register:
- Loads the decoded head entry when it is empty or being transferred, and the FIFO is non-empty.
- Otherwise it holds its value stable.
REQ-021 Latency and throughput:
- Entry accepted at edge N into an empty stage gives out_valid = 1 after edge N+1.
- Sustained rate is one instruction per cycle.
REQ-022 Total capacity is DEPTH+1 (FIFO plus output register).
REQ-023 in_ready = !rst && (FIFO not full).
REQ-024 in_ready is combinational from FIFO occupancy only, never from out_ready.
REQ-025 Simultaneous write and read on a full FIFO: the write is refused because in_ready = 0.
REQ-026 Simultaneous write and read on an empty FIFO: the write enters the FIFO and the bypass is not used.
REQ-027 Field extraction:
- opcode = [31:26], rs = [25:21], rt = [20:16], rd = [15:11].
- shamt = [10:6], funct = [5:0].
REQ-028 Immediate extension:
- imm_ext is zero-extended for opcodes 0x0C, 0x0D and 0x0E.
- imm_ext is sign-extended for all other opcodes.
REQ-029 iclass:
- R when opcode is 0x00.
- J when opcode is 0x02 or 0x03.
- I otherwise.
REQ-030 pc_plus4 = pc + 4, modulo 2^XLEN.
REQ-031 jump_target = {pc_plus4[XLEN-1:28], instr[25:0], 2'b00}.
REQ-032 branch_target = pc_plus4 + (sign-extended imm << 2), modulo 2^XLEN, wrapping silently.
REQ-033 Decoded outputs are registered; no combinational path from instr or pc to any output.
REQ-034 FIFO pointers are log2(DEPTH)+1 bits:
- Full when the pointers differ only in the MSB.
- Empty when the pointers are equal.
- Pointers wrap naturally.
REQ-035 flush:
- Next cycle: FIFO empty and out_valid = 0.
- An input transfer in the same cycle is discarded.
- flush has priority over all writes.
REQ-036 Bundle outputs are don't-care while out_valid = 0; the verifier checks them only when out_valid = 1.

Reset
REQ-037 While rst = 1: pointers = 0, out_valid = 0, in_ready = 0.
REQ-038 Bundle output registers reset to 0.
REQ-039 Reset mid-operation discards all contents, with the same effect as flush.
REQ-040 rst has priority over flush.

Structure
REQ-041 Shared package decode_pkg holds:
- opcode constants (OP_RTYPE, OP_J, OP_JAL, OP_ANDI, OP_ORI, OP_XORI);
- the iclass encoding constants;
- the FIFO entry width constant (32+XLEN).
REQ-042 One sub-module, sync_fifo (parameters WIDTH and DEPTH, same clk/rst), holds the entry storage; decode logic and the output register live in the top module.

Verification
REQ-043 R-type: push instr 0x012A4020, pc 0x00400000, out_ready = 1.
- Expect one cycle later: opcode 0, rs 9, rt 10, rd 8, shamt 0, funct 0x20.
- Expect iclass 0 and pc_plus4 0x00400004.
REQ-044 Extension: push 0x2108FFFF -> imm_ext 0xFFFFFFFF, iclass 1; then push 0x3508FFFF -> imm_ext 0x0000FFFF.
REQ-045 Targets:
- Push 0x08000004 with pc 0x00400000 -> jump_target 0x00000010, iclass 2.
- Push 0x1109FFFE with pc 0x00400010 -> branch_target 0x0040000C.
REQ-046 Back-pressure: out_ready = 0 and DEPTH = 2, push 4 instructions.
- Exactly 3 are accepted, then in_ready = 0.
- Raise out_ready: outputs appear in order, one per cycle, with no loss or duplication.
REQ-047 Flush: fill the stage and assert flush together with in_valid.
- Next cycle: out_valid = 0, in_ready = 1, and the concurrent input never appears.
REQ-048 Reset mid-stream: assert rst for 1 cycle with 2 entries buffered.
- out_valid = 0 and in_ready = 0 during rst; afterwards the stage is empty and a new push decodes correctly.
